// File: rtl/keypad_pkg.sv
// Shared types, sizes and helper functions for the 4x4 hex keypad scanner.
package keypad_pkg;

    localparam int KEY_W = 4;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD
    } state_e;

    // Key numbering is row-major: 4*row_idx + col_idx.
    function automatic logic [KEY_W-1:0] key_code_of(input logic [1:0] row_idx,
                                                     input logic [1:0] col_idx);
        return {row_idx, col_idx};
    endfunction

    // Rows are active-low; the lowest-numbered low row wins.
    function automatic logic [1:0] lowest_low_row(input logic [ROWS-1:0] row);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (!row[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic [COLS-1:0] col_drive(input logic [1:0] col_idx);
        return ~(4'b0001 << col_idx);
    endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad-side and key-report signals of the scanner; clear/value exist only
// when KEYPAD_ACCUM_EN is defined.
interface keypad_if;
    import keypad_pkg::*;

    logic [ROWS-1:0]  row;
    logic [COLS-1:0]  col;
    logic [KEY_W-1:0] key_code;
    logic             key_valid;
    logic             key_held;
`ifdef KEYPAD_ACCUM_EN
    logic             clear;
    logic [15:0]      value;

    modport master (input row, clear, output col, key_code, key_valid, key_held, value);
    modport slave  (output row, clear, input col, key_code, key_valid, key_held, value);
`else
    modport master (input row, output col, key_code, key_valid, key_held);
    modport slave  (output row, input col, key_code, key_valid, key_held);
`endif

endinterface

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for asynchronous active-low inputs; resets to all-ones
// so an idle (pulled-up) line is what the logic sees out of reset.
module keypad_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments make meta->q a true two-stage shift;
    // blocking ones would collapse it into a single flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 hex keypad scanner: column walk, debounce of press and release, one-cycle
// key_valid pulse. Define KEYPAD_ACCUM_EN to add the 16-bit nibble accumulator.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_TICKS = 8
) (
    input  logic     clk,
    input  logic     reset,
    keypad_if.master kif
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_TICKS - 1);

    logic [ROWS-1:0]  row_s;
    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    state_e           state;
    logic [1:0]       col_idx;
    logic [1:0]       cap_row;
    logic [DEB_W-1:0] deb_cnt;
    logic [DEB_W-1:0] rel_cnt;
    logic [COLS-1:0]  col_q;
    logic [KEY_W-1:0] key_code_q;
    logic             key_valid_q;
    logic             key_held_q;
    logic             cap_low;
    logic             accept;
    logic [KEY_W-1:0] accept_code;

    keypad_sync #(.WIDTH(ROWS)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (kif.row),
        .q     (row_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    assign tick        = (div_cnt == DIV_LAST);
    assign cap_low     = !row_s[cap_row];
    assign accept      = tick && (state == DEBOUNCE) && cap_low && (deb_cnt == DEB_LAST);
    assign accept_code = key_code_of(cap_row, col_idx);

    // col stays frozen outside SCAN, so col_idx is also the captured column.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= SCAN;
            col_idx     <= 2'd0;
            col_q       <= 4'b1110;
            cap_row     <= 2'd0;
            deb_cnt     <= '0;
            rel_cnt     <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (tick) begin
                unique case (state)
                    SCAN: begin
                        if (&row_s) begin
                            col_idx <= col_idx + 2'd1;
                            col_q   <= col_drive(col_idx + 2'd1);
                        end else begin
                            cap_row <= lowest_low_row(row_s);
                            deb_cnt <= '0;
                            state   <= DEBOUNCE;
                        end
                    end
                    DEBOUNCE: begin
                        if (accept) begin
                            key_code_q  <= accept_code;
                            key_valid_q <= 1'b1;
                            key_held_q  <= 1'b1;
                            rel_cnt     <= '0;
                            state       <= HELD;
                        end else if (cap_low) begin
                            deb_cnt <= deb_cnt + DEB_W'(1);
                        end else begin
                            col_idx <= col_idx + 2'd1;
                            col_q   <= col_drive(col_idx + 2'd1);
                            state   <= SCAN;
                        end
                    end
                    HELD: begin
                        if (!cap_low) begin
                            if (rel_cnt == DEB_LAST) begin
                                rel_cnt    <= '0;
                                key_held_q <= 1'b0;
                                col_idx    <= col_idx + 2'd1;
                                col_q      <= col_drive(col_idx + 2'd1);
                                state      <= SCAN;
                            end else begin
                                rel_cnt <= rel_cnt + DEB_W'(1);
                            end
                        end else begin
                            rel_cnt <= '0;
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end

    assign kif.col       = col_q;
    assign kif.key_code  = key_code_q;
    assign kif.key_valid = key_valid_q;
    assign kif.key_held  = key_held_q;

`ifdef KEYPAD_ACCUM_EN
    logic [15:0] value_q;

    // clear has priority over a coincident accepted key.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q <= '0;
        end else if (kif.clear) begin
            value_q <= '0;
        end else if (accept) begin
            value_q <= {value_q[11:0], accept_code};
        end
    end

    assign kif.value = value_q;
`endif

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a behavioural 4x4 keypad drives the rows, a scoreboard
// queue holds expected key reports and a negedge monitor checks each pulse.
module tb_keypad_scan;

    typedef struct {
        logic [3:0]  code;
        logic [15:0] value;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [15:0] pressed;
    logic [3:0]  row_v;
    int          cyc;
    int          errors;
    int          checks;
    logic [15:0] model_value;
    exp_t        exp_q[$];
    logic        prev_valid;
    logic        prev_held;

    keypad_if kif();

    keypad_scan #(
        .SCAN_DIV       (4),
        .DEBOUNCE_TICKS (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kif   (kif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A row reads low when any pressed key in it sits in a driven (low) column.
    always_comb begin
        row_v = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4 + c] && !kif.col[c]) row_v[r] = 1'b0;
            end
        end
    end
    assign kif.row = row_v;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_key(input int k, input bit clr);
        exp_t e;
        e.code = 4'(k);
        if (clr) model_value = 16'h0;
        else     model_value = {model_value[11:0], 4'(k)};
        e.value = model_value;
        exp_q.push_back(e);
    endtask

    task automatic wait_valid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (kif.key_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_release(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!kif.key_held) begin
                done = 1'b1;
                break;
            end
        end
        check("release_timeout", done, 1'b1);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic press_release(input int k, input bit clr);
        bit seen;
        expect_key(k, clr);
`ifdef KEYPAD_ACCUM_EN
        kif.clear = clr;
`endif
        pressed[k] = 1'b1;
        wait_valid(80, seen);
        check("press_timeout", seen, 1'b1);
`ifdef KEYPAD_ACCUM_EN
        @(negedge clk);
        kif.clear = 1'b0;
`endif
        repeat ($urandom_range(0, 12)) @(negedge clk);
        pressed[k] = 1'b0;
        wait_release(40);
        repeat (4) @(negedge clk);
    endtask

    // Scoreboard monitor: every key_valid pops one expected report.
    always @(negedge clk) begin
        if (reset) begin
            prev_valid <= 1'b0;
            prev_held  <= 1'b0;
        end else begin
            exp_t e;
            check("col_one_low", $countones(~kif.col), 1);
            if (kif.key_valid) begin
                check("valid_not_back_to_back", prev_valid, 1'b0);
                check("held_rises_with_valid", {prev_held, kif.key_held}, 2'b01);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_key_valid: got code %0d expected no pulse (t=%0t)",
                             kif.key_code, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("key_code", kif.key_code, e.code);
`ifdef KEYPAD_ACCUM_EN
                    check("value", kif.value, e.value);
`endif
                end
            end
            prev_valid <= kif.key_valid;
            prev_held  <= kif.key_held;
        end
    end

    initial begin
        bit seen;
        int k;
        errors      = 0;
        checks      = 0;
        model_value = 16'h0;
        pressed     = 16'h0;
        reset       = 1'b1;
`ifdef KEYPAD_ACCUM_EN
        kif.clear   = 1'b0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset mid-scan, then the column walk from col 0.
        wait_cyc(6);
        check("col_before_reset", kif.col, 4'b1101);
        reset = 1'b1;
        #1;
        check("reset_col", kif.col, 4'b1110);
        check("reset_valid", kif.key_valid, 1'b0);
        check("reset_held", kif.key_held, 1'b0);
`ifdef KEYPAD_ACCUM_EN
        check("reset_value", kif.value, 16'h0);
`endif
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        wait_cyc(3);  check("walk_c3", kif.col, 4'b1110);
        wait_cyc(4);  check("walk_c4", kif.col, 4'b1101);
        wait_cyc(8);  check("walk_c8", kif.col, 4'b1011);
        wait_cyc(12); check("walk_c12", kif.col, 4'b0111);
        wait_cyc(16); check("walk_c16", kif.col, 4'b1110);

        // Clean press of key 9 (row 2, col 1) held across reset release:
        // col 1 driven after edge 4, row synced by edge 6, detected at tick 8,
        // accepted at tick 20.
        @(negedge clk);
        reset = 1'b1;
        model_value = 16'h0;
        pressed[9] = 1'b1;
        expect_key(9, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_valid(40, seen);
        check("clean_seen", seen, 1'b1);
        check("clean_latency", cyc, 20);
        // Released input synced by edge 22; released ticks 24, 28, 32.
        pressed[9] = 1'b0;
        wait_cyc(31); check("held_before_release_done", kif.key_held, 1'b1);
        wait_cyc(32); check("held_after_release_done", kif.key_held, 1'b0);
        check("scan_resumes_col2", kif.col, 4'b1011);

        // Bounce: key 0 detected at tick 4, high again at tick 12 (2nd debounce tick).
        @(negedge clk);
        reset = 1'b1;
        model_value = 16'h0;
        pressed = 16'h0;
        pressed[0] = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        wait_cyc(9);
        pressed[0] = 1'b0;
        wait_cyc(12);
        check("bounce_back_to_scan_col", kif.col, 4'b1101);
        check("bounce_no_held", kif.key_held, 1'b0);
        wait_cyc(20);
        expect_key(0, 1'b0);
        pressed[0] = 1'b1;
        wait_valid(80, seen);
        check("repress_seen", seen, 1'b1);
        pressed[0] = 1'b0;
        wait_release(40);
        repeat (4) @(negedge clk);

        // Two keys in col 3; a third key pressed while held waits for release.
        expect_key(3, 1'b0);
        pressed[3]  = 1'b1;
        pressed[15] = 1'b1;
        wait_valid(80, seen);
        check("two_key_seen", seen, 1'b1);
        pressed[4] = 1'b1;
        repeat (30) @(negedge clk);
        check("still_held_with_other_key", kif.key_held, 1'b1);
        expect_key(4, 1'b0);
        pressed[3]  = 1'b0;
        pressed[15] = 1'b0;
        wait_valid(80, seen);
        check("queued_key_seen", seen, 1'b1);
        pressed[4] = 1'b0;
        wait_release(40);
        repeat (4) @(negedge clk);

        // Reset while a key is held, then one fresh report of the same key.
        expect_key(6, 1'b0);
        pressed[6] = 1'b1;
        wait_valid(80, seen);
        check("pre_reset_seen", seen, 1'b1);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        model_value = 16'h0;
        #1;
        check("reset_drops_held", kif.key_held, 1'b0);
        check("reset_held_col", kif.col, 4'b1110);
`ifdef KEYPAD_ACCUM_EN
        check("reset_held_value", kif.value, 16'h0);
`endif
        repeat (2) @(negedge clk);
        expect_key(6, 1'b0);
        reset = 1'b0;
        wait_valid(80, seen);
        check("post_reset_redetect", seen, 1'b1);
        pressed[6] = 1'b0;
        wait_release(40);
        repeat (4) @(negedge clk);

`ifdef KEYPAD_ACCUM_EN
        @(negedge clk);
        reset = 1'b1;
        model_value = 16'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        press_release(1, 1'b0);
        press_release(2, 1'b0);
        press_release(3, 1'b0);
        press_release(4, 1'b0);
        check("value_1234", kif.value, 16'h1234);
        press_release(15, 1'b0);
        check("value_234F", kif.value, 16'h234F);
        press_release(5, 1'b1);
        check("value_cleared", kif.value, 16'h0);
        press_release(7, 1'b0);
        check("value_after_clear", kif.value, 16'h0007);
`endif

        // Random clean presses mixed with glitches too short to be accepted.
        for (int n = 0; n < 24; n++) begin
            k = $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) begin
                pressed[k] = 1'b1;
                repeat ($urandom_range(1, 8)) @(negedge clk);
                pressed[k] = 1'b0;
                repeat (10) @(negedge clk);
            end else begin
                press_release(k, 1'b0);
            end
        end

        repeat (20) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Hex keypad scanner: the input-side counterpart to the board's multiplexed 7-segment display driver. Drives one column of a 4x4 matrix keypad low at a time, samples the four rows, debounces a detected press, and reports a 4-bit key code with a one-cycle valid pulse. An optional accumulator shifts accepted nibbles into a 16-bit value for direct display.

## Interface
- SCAN_DIV, 1000: clk cycles per scan tick (column dwell); ≥ 4.
- DEBOUNCE_TICKS, 8: consecutive matching ticks needed to accept a press or a release; ≥ 1.

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- row  in  4  keypad rows, active-low (external pull-ups), asynchronous
- col  out  4  keypad column drive, active-low, exactly one bit low at all times
- key_code  out  4  code of last accepted key = 4*row_idx + col_idx
- key_valid  out  1  one-cycle pulse when key_code updates
- key_held  out  1  high while the accepted key is still pressed
- clear  in  1  sync clear of value (only with KEYPAD_ACCUM_EN)
- value  out  16  nibble accumulator (only with KEYPAD_ACCUM_EN)

## Operation
- row passes through a 2-FF synchronizer (reset value 4'b1111). All decisions use the synchronized row.
- Prescaler counts 0..SCAN_DIV-1 and wraps. tick = 1 in the cycle where count == SCAN_DIV-1.
- col_idx is 2 bits, col = ~(1 << col_idx). Row is evaluated only in tick cycles.
- State machine:
  - SCAN: on tick with no row low, col_idx increments mod 4. On tick with any row low, capture row_idx (lowest low row wins) and col_idx, clear deb_cnt, go to DEBOUNCE. col is frozen.
  - DEBOUNCE: on tick with the captured row still low, deb_cnt++. When the match occurs with deb_cnt == DEBOUNCE_TICKS-1, load key_code, pulse key_valid, and go to HELD. On tick with the captured row high, col_idx increments and the FSM returns to SCAN.
  - HELD: key_held = 1 and col stays frozen. On tick with the captured row high, rel_cnt++. On tick with the row low, rel_cnt = 0. When rel_cnt reaches DEBOUNCE_TICKS, go to SCAN, col_idx increments, and key_held drops.
- Other keys pressed during DEBOUNCE/HELD are ignored. They are reported only after release, if still pressed.
- Reset values: col = 4'b1110, key_code = 0, key_valid = 0, key_held = 0, value = 0, state = SCAN, all counters 0.
- reset mid-press: return to SCAN immediately. A still-held key is re-detected and re-debounced, and then produces a new key_valid.

## Timing
- Row change to synchronized row: 2 clk.
- Press detection: first tick at which the pressed key's column is driven.
- Detection tick to key_valid: exactly DEBOUNCE_TICKS further ticks. key_valid and key_code are registered and change on the clk edge after that tick.
- key_held rises in the same cycle as key_valid. It falls on the edge after the DEBOUNCE_TICKS-th consecutive released tick.
- key_valid is never high in two consecutive cycles. There is at most one pulse per physical press.

## Configuration
- KEYPAD_ACCUM_EN defined:
  - clear and value ports exist.
  - On key_valid, value <= {value[11:0], key_code} in the same edge as the key_code update.
  - clear = 1 sets value to 0 on the next edge. If clear and key_valid coincide, clear wins.
- KEYPAD_ACCUM_EN undefined: clear and value ports and their logic are absent. All other behaviour is identical.

## Structure
- Package keypad_pkg holds:
  - state enum (SCAN, DEBOUNCE, HELD)
  - KEY_W = 4, ROWS = 4, COLS = 4
  - function mapping (row_idx, col_idx) to key_code
  - lowest-low-row priority encoder function
- Sub-module keypad_sync: parameterizable-width 2-FF synchronizer with async reset to all-ones.
- Everything else lives in keypad_scan.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE_TICKS=3.
- Reset: assert reset mid-scan -> col = 1110, key_valid/key_held = 0, value = 0. After release, col walks 1110→1101→1011→0111→1110, one step every 4 clk.
- Clean press of row 2 / col 1 -> exactly one key_valid pulse with key_code = 9, 3 ticks after detection. key_held = 1 until 3 released ticks, then scanning resumes from col 2.
- Bounce: row toggles high on the 2nd debounce tick -> no key_valid, FSM back to SCAN. A stable re-press later yields a single pulse.
- Two keys, row 0 and row 3 in col 3 simultaneously -> key_code = 3. Pressing col 0 row 1 while it is held -> no pulse until col 3 key release completes, then key_code = 4.
- Accumulator (KEYPAD_ACCUM_EN): press keys 1, 2, 3, 4 in order -> value = 16'h1234. A fifth press of key 15 -> 16'h234F. clear coincident with key_valid -> value = 0.
- Reset while key held -> key_held = 0 immediately. After reset, the still-pressed key produces one fresh key_valid.
